ntt_out_collector: RTL and testbench

- Receiving end of the NTT/INTT output stream (out_en + two coefficients per cycle).
- Gathers one full polynomial per bank into a two-bank ping-pong buffer, optionally undoing bit-reversed order.
- Replays each completed polynomial to a downstream consumer over a valid/ready stream, one pair per cycle.
- Sits between ntt/intt and the PWM input or the memory writeback path; lets the non-stallable NTT pipeline feed a back-pressured consumer.

---
 rtl/ntt_out_collector_pkg.sv | 30 +++
 rtl/ntt_out_collector_if.sv | 29 ++
 rtl/ntt_out_collector_pp_bank_ram.sv | 34 +++
 rtl/ntt_out_collector.sv | 147 ++++++++++++++
 tb/tb_ntt_out_collector.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_out_collector_pkg.sv
// rtl/ntt_out_collector_pkg.sv - shared types, widths and helpers for the NTT output collector
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package ntt_out_collector_pkg;

  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int N_DEFAULT  = 256;
  localparam int PAIR_AW    = $clog2(N_DEFAULT / 2);

  typedef logic [1:0][DATA_WIDTH-1:0] pair_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_PRIME  = 2'd1,
    R_STREAM = 2'd2
  } rd_state_t;

  // Reverses the low w bits of v; bits above w come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_out_collector_if.sv
// rtl/ntt_out_collector_if.sv - input pair stream, output pair stream and status of the collector
interface ntt_out_collector_if #(
  parameter int DW = ntt_out_collector_pkg::DATA_WIDTH,
  parameter int AW = ntt_out_collector_pkg::PAIR_AW
) ();

  logic                 in_en;
  logic [1:0][DW-1:0]   in;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0][DW-1:0]   out_data;
  logic [AW-1:0]        out_idx;
  logic                 out_last;
  logic                 full;
  logic                 overflow;
  logic                 clr_ovf;

  // The collector is the master of the output stream.
  modport master (
    input  in_en, in, out_ready, clr_ovf,
    output out_valid, out_data, out_idx, out_last, full, overflow
  );

  modport slave (
    output in_en, in, out_ready, clr_ovf,
    input  out_valid, out_data, out_idx, out_last, full, overflow
  );

endinterface

// File: rtl/ntt_out_collector_pp_bank_ram.sv
// rtl/ntt_out_collector_pp_bank_ram.sv - two-bank pair RAM, one write port, one registered read port
module pp_bank_ram #(
  parameter int W  = 32,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW:0]   raddr,
  output logic [W-1:0]  rdata
);

  // Address MSB selects the bank.
  logic [W-1:0] mem [0:(1<<(AW+1))-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds between reads so the presented pair stays stable under back-pressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ntt_out_collector.sv
// rtl/ntt_out_collector.sv - ping-pong polynomial collector between NTT output and a back-pressured consumer
module ntt_out_collector
  import ntt_out_collector_pkg::*;
#(
  parameter int DW     = DATA_WIDTH,
  parameter int N      = 256,
  parameter int BITREV = 0
) (
  input  logic                clk,
  input  logic                rst,
  ntt_out_collector_if.master bus
);

  localparam int            AW   = $clog2(N / 2);
  localparam logic [AW-1:0] LAST = AW'(N / 2 - 1);

  rd_state_t      state;
  logic           wbank;
  logic           rbank;
  logic [1:0]     bank_full;
  logic [AW-1:0]  wcnt;
  logic [AW-1:0]  rcnt;
  logic           out_valid_q;
  logic           out_last_q;
  logic [AW-1:0]  out_idx_q;
  logic           overflow_q;

  logic           wr_ok;
  logic           wr_done;
  logic           rel;
  logic           rd_en;
  logic [15:0]    wcnt_rev;
  logic [AW-1:0]  waddr_lo;
  logic [AW-1:0]  raddr_lo;
  logic [1:0]     set_mask;
  logic [1:0]     clr_mask;
  logic [2*DW-1:0] rdata;

  // Write decisions use only registered flags, so a same-edge release cannot rescue an in_en.
  assign wr_ok    = bus.in_en && !bank_full[wbank];
  assign wr_done  = wr_ok && (wcnt == LAST);
  assign wcnt_rev = bitrev(16'(wcnt), AW);
  assign waddr_lo = (BITREV != 0) ? wcnt_rev[AW-1:0] : wcnt;

  assign rel      = (state == R_STREAM) && bus.out_ready && out_last_q;
  assign rd_en    = (state == R_PRIME) ||
                    ((state == R_STREAM) && bus.out_ready && !out_last_q);
  assign raddr_lo = (state == R_PRIME) ? '0 : rcnt;

  assign set_mask = wr_done ? (2'b01 << wbank) : 2'b00;
  assign clr_mask = rel     ? (2'b01 << rbank) : 2'b00;

  pp_bank_ram #(
    .W  (2 * DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr ({wbank, waddr_lo}),
    .wdata (bus.in),
    .re    (rd_en),
    .raddr ({rbank, raddr_lo}),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt      <= '0;
      wbank     <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full | set_mask) & ~clr_mask;
      if (wr_ok) begin
        wcnt <= wr_done ? '0 : wcnt + 1'b1;
        if (wr_done) begin
          wbank <= ~wbank;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
    end else if (bus.in_en && bank_full[wbank]) begin
      overflow_q <= 1'b1;
    end
  end

  // rcnt always holds the address of the pair to prefetch next.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= R_IDLE;
      rbank       <= 1'b0;
      rcnt        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      case (state)
        R_IDLE: begin
          if (bank_full[rbank]) begin
            state <= R_PRIME;
          end
        end
        R_PRIME: begin
          state       <= R_STREAM;
          out_valid_q <= 1'b1;
          out_idx_q   <= '0;
          out_last_q  <= (LAST == '0);
          rcnt        <= AW'(1);
        end
        R_STREAM: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              rbank       <= ~rbank;
              rcnt        <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_idx_q   <= '0;
              state       <= bank_full[~rbank] ? R_PRIME : R_IDLE;
            end else begin
              out_idx_q  <= rcnt;
              out_last_q <= (rcnt == LAST);
              rcnt       <= rcnt + 1'b1;
            end
          end
        end
        default: begin
          state       <= R_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = rdata;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.full      = &bank_full;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ntt_out_collector.sv
// tb/tb_ntt_out_collector.sv - randomized self-checking bench for ntt_out_collector, natural and bit-reversed
module tb_ntt_out_collector;
  import ntt_out_collector_pkg::*;

  localparam int DW = 16;
  localparam int N  = 256;
  localparam int NP = N / 2;
  localparam int AW = 7;

  typedef struct packed {
    logic [2*DW-1:0] d;
    logic [AW-1:0]   idx;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_en = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [DW-1:0] in0 = '0;
  logic [DW-1:0] in1 = '0;

  ntt_out_collector_if #(.DW(DW), .AW(AW)) bus0 ();
  ntt_out_collector_if #(.DW(DW), .AW(AW)) bus1 ();

  ntt_out_collector #(.DW(DW), .N(N), .BITREV(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ntt_out_collector #(.DW(DW), .N(N), .BITREV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.in_en = in_en;   assign bus1.in_en = in_en;
  assign bus0.in[0] = in0;     assign bus1.in[0] = in0;
  assign bus0.in[1] = in1;     assign bus1.in[1] = in1;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;
  assign bus0.clr_ovf = clr_ovf;     assign bus1.clr_ovf = clr_ovf;

  logic            v    [2];
  logic [2*DW-1:0] od   [2];
  logic [AW-1:0]   oi   [2];
  logic            ol   [2];
  logic            ofull[2];
  logic            oovf [2];
  assign v[0] = bus0.out_valid;  assign v[1] = bus1.out_valid;
  assign od[0] = bus0.out_data;  assign od[1] = bus1.out_data;
  assign oi[0] = bus0.out_idx;   assign oi[1] = bus1.out_idx;
  assign ol[0] = bus0.out_last;  assign ol[1] = bus1.out_last;
  assign ofull[0] = bus0.full;   assign ofull[1] = bus1.full;
  assign oovf[0] = bus0.overflow; assign oovf[1] = bus1.overflow;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int brev7(input int x);
    int r = 0;
    for (int k = 0; k < AW; k++) if (((x >> k) & 1) != 0) r |= 1 << (AW - 1 - k);
    return r;
  endfunction

  // Reference: polynomials held = slots waiting to be read; writer stalls only when both are held.
  exp_t            expq0[$];
  exp_t            expq1[$];
  int              held  [2] = '{0, 0};
  bit              movf  [2] = '{0, 0};
  int              mwcnt [2] = '{0, 0};
  logic [2*DW-1:0] part  [2][NP];
  int              hs_cnt[2] = '{0, 0};
  int              gap_cnt = 0;
  int              last_gap = -1;
  bit              in_gap = 0;

  always @(negedge clk) begin
    exp_t f;
    int   qs;
    int   addr;
    bit   rel;
    bit   inc;
    if (in_gap) begin
      if (v[0]) begin
        last_gap = gap_cnt;
        in_gap = 0;
      end else gap_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      qs = (i == 0) ? expq0.size() : expq1.size();
      f = '0;
      if (qs > 0) f = (i == 0) ? expq0[0] : expq1[0];
      chk($sformatf("full[%0d]", i), ofull[i], held[i] == 2);
      chk($sformatf("overflow[%0d]", i), oovf[i], movf[i]);
      if (v[i]) begin
        if (qs == 0) chk($sformatf("valid_without_data[%0d]", i), 1, 0);
        else begin
          chk($sformatf("data[%0d] idx %0d", i, f.idx), od[i], f.d);
          chk($sformatf("idx[%0d]", i), oi[i], f.idx);
          chk($sformatf("last[%0d] idx %0d", i, f.idx), ol[i], f.last);
        end
      end
      if (!rst) begin
        held[i] = 0; movf[i] = 0; mwcnt[i] = 0;
        if (i == 0) expq0.delete(); else expq1.delete();
        in_gap = 0;
      end else begin
        rel = 0;
        inc = 0;
        if (v[i] && out_ready && qs > 0) begin
          hs_cnt[i]++;
          rel = f.last;
          if (i == 0) begin
            void'(expq0.pop_front());
            if (f.last) begin in_gap = 1; gap_cnt = 0; end
          end else void'(expq1.pop_front());
        end
        if (in_en) begin
          if (held[i] == 2) begin
            if (!clr_ovf) movf[i] = 1;
          end else begin
            addr = (i == 0) ? mwcnt[i] : brev7(mwcnt[i]);
            part[i][addr] = {in1, in0};
            mwcnt[i]++;
            if (mwcnt[i] == NP) begin
              for (int j = 0; j < NP; j++) begin
                if (i == 0) expq0.push_back('{part[i][j], AW'(j), j == NP - 1});
                else        expq1.push_back('{part[i][j], AW'(j), j == NP - 1});
              end
              mwcnt[i] = 0;
              inc = 1;
            end
          end
        end
        if (clr_ovf) movf[i] = 0;
        held[i] = held[i] + int'(inc) - int'(rel);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    in_en = 0;
    out_ready = 1;
    for (int c = 0; c < 1000; c++) begin
      if (expq0.size() == 0 && expq1.size() == 0 && !v[0] && !v[1]) break;
      step();
    end
    chk({name, "_drained"}, expq0.size() + expq1.size(), 0);
  endtask

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_en = 1; in0 = a; in1 = b;
    step();
  endtask

  int h0;
  int sent;
  bit found;

  initial begin
    repeat (3) step();
    chk("rst_valid", v[0], 0);
    chk("rst_idx", oi[0], 0);
    chk("rst_data", od[0], 0);
    chk("rst_last", ol[0], 0);
    chk("rst_full", ofull[0], 0);
    chk("rst_ovf", oovf[0], 0);
    rst = 1;
    step();

    // single polynomial, ascending coefficients, pinned latency and ordering
    out_ready = 1;
    for (int k = 0; k < NP; k++) push_pair(DW'(2 * k), DW'(2 * k + 1));
    in_en = 0;
    @(negedge clk); chk("lat_t0_valid", v[0], 0);
    step(); @(negedge clk); chk("lat_t1_valid", v[0], 0);
    step(); @(negedge clk);
    chk("lat_t2_valid", v[0], 1);
    chk("lat_t2_idx", oi[0], 0);
    chk("first_pair_nat", od[0], 32'h0001_0000);
    chk("first_pair_rev", od[1], 32'h0001_0000);
    step(); @(negedge clk);
    chk("second_pair_nat", od[0], 32'h0003_0002);
    chk("second_pair_rev", od[1], 32'h0081_0080);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (v[0] && oi[0] == AW'(NP - 1)) found = 1;
    end
    chk("reached_idx127", found, 1);
    chk("last_pair_nat", od[0], 32'h00FF_00FE);
    chk("last_flag_127", ol[0], 1);
    drain("single");

    // back-pressure 1,0,0,1 with in_en gaps every third cycle
    h0 = hs_cnt[0];
    sent = 0;
    for (int c = 0; sent < NP || c < 2000; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      in_en = (sent < NP) && (c % 3 != 2);
      in0 = DW'($urandom); in1 = DW'($urandom);
      if (in_en) sent++;
      step();
      if (sent >= NP && expq0.size() == 0 && !v[0]) break;
    end
    drain("backpressure");
    chk("backpressure_handshakes", hs_cnt[0] - h0, NP);

    // three polynomials with the consumer stalled
    h0 = hs_cnt[0];
    out_ready = 0;
    for (int p = 0; p < 3 * NP; p++) begin
      push_pair(DW'($urandom), DW'($urandom));
      if (p == 2 * NP - 1) begin
        chk("full_after_256", ofull[0], 1);
        chk("no_ovf_at_256", oovf[0], 0);
      end
      if (p == 2 * NP) chk("ovf_at_257", oovf[0], 1);
    end
    drain("overflow");
    chk("overflow_handshakes", hs_cnt[0] - h0, 2 * NP);
    chk("ovf_sticky", oovf[0], 1);
    clr_ovf = 1; step(); clr_ovf = 0;
    chk("ovf_cleared", oovf[0], 0);

    // back-to-back polynomials
    h0 = hs_cnt[0];
    last_gap = -1;
    out_ready = 1;
    for (int k = 0; k < 2 * NP; k++) push_pair(DW'($urandom), DW'($urandom));
    drain("b2b");
    chk("b2b_handshakes", hs_cnt[0] - h0, 2 * NP);
    chk("b2b_gap", last_gap, 1);
    chk("b2b_no_ovf", oovf[0], 0);

    // reset with a stream in flight and a partly written second bank
    out_ready = 0;
    for (int k = 0; k < NP + 60; k++) push_pair(DW'($urandom), DW'($urandom));
    in_en = 0;
    out_ready = 1;
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (v[0] && oi[0] == AW'(40)) found = 1;
      else step();
    end
    chk("reached_idx40", found, 1);
    rst = 0; step(); rst = 1;
    @(negedge clk);
    chk("midrst_valid", v[0], 0);
    chk("midrst_full", ofull[0], 0);
    h0 = hs_cnt[0];
    for (int k = 0; k < NP; k++) push_pair(DW'(3 * k), DW'(3 * k + 1));
    drain("after_reset");
    chk("after_reset_handshakes", hs_cnt[0] - h0, NP);

    // random traffic: balanced, then a slow consumer to provoke overflow
    for (int c = 0; c < 900; c++) begin
      in_en = ($urandom_range(0, 9) < 7);
      in0 = DW'($urandom); in1 = DW'($urandom);
      out_ready = (c < 450) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3);
      clr_ovf = ($urandom_range(0, 59) == 0);
      step();
    end
    clr_ovf = 0;
    drain("random");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
